// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter merging NREQ requesters onto one shared FIFO write port.
// Optional: define FIFO_WR_ARB_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 16,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wen,
  output logic [WIDTH-1:0]        fifo_wdata,
  output logic [$clog2(NREQ)-1:0] grant_id,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  output logic [15:0]             stall_cnt,
`endif
  output logic                    busy
);

  localparam int         OW       = $clog2(NREQ);
  localparam logic [3:0] CNT_LAST = 4'(BURST_MAX);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [OW-1:0]    owner, owner_nxt;
  logic [OW-1:0]    rr_ptr, rr_nxt;
  logic [OW-1:0]    pick, idx;
  logic [3:0]       cnt, cnt_nxt;
  logic             found;
  logic [WIDTH-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  // NREQ is a power of two, so the rotating index wraps by plain overflow.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + OW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    req_ready = '0;
    fifo_wen  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = pick;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        req_ready[owner] = ~fifo_full;
        fifo_wen         = req_valid[owner] & ~fifo_full;
        // A vanished owner releases even against a full FIFO; a full FIFO alone only holds.
        if (!req_valid[owner]) begin
          state_nxt = IDLE;
          rr_nxt    = owner + OW'(1);
        end else if (!fifo_full) begin
          cnt_nxt = cnt + 4'd1;
          if (cnt_nxt == CNT_LAST) begin
            state_nxt = IDLE;
            rr_nxt    = owner + OW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_wdata = data_arr[owner];
  assign grant_id   = owner;
  assign busy       = (state == BURST);

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == BURST) && req_valid[owner] && fifo_full
                 && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: reset checks, vector table, corner sequences, random run vs model.
module tb_fifo_wr_arb;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 16;
  localparam int BURST_MAX = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wen;
  logic [WIDTH-1:0]      fifo_wdata;
  logic [1:0]            grant_id;
  logic                  busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic [3:0] ready;
    logic       wen;
    logic       busy;
    logic [1:0] grant;
  } vec_t;

  vec_t tbl [16];

  // reference model state (plain integers)
  int          head [NREQ];
  bit          m_busy;
  int          m_owner, m_rr, m_cnt, m_j, dut_writes, model_writes;
  logic [15:0] m_stall;
  logic [3:0]  exp_ready;
  logic        exp_wen;
  int          word, k;
  logic [8:0]  pat31;
  logic [10:0] wen33, busy33;
  logic [15:0] s0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] w);
    req_data[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [15:0] mkword(input int i, input int n);
    return {4'(i), 12'(n)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
    tbl[3]  = '{4'b0110, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2};
    tbl[4]  = '{4'b0110, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
    tbl[5]  = '{4'b0010, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2};
    tbl[6]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    tbl[8]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    tbl[9]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    tbl[10] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    tbl[11] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[12] = '{4'b0011, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1};
    tbl[13] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1};
    tbl[14] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[15] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};

    // reset state
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) set_data(i, 16'h5A00 + 16'(i));
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_wen", 32'(fifo_wen), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_wdata", 32'(fifo_wdata), 32'h5A00);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("rst_stall", 32'(stall_cnt), 32'h0);
`endif

    // single requester, words 1..6
    do_reset;
    word  = 1;
    pat31 = 9'b011011110;
    for (int c = 1; c <= 9; c++) begin
      req_valid = (word <= 6) ? 4'b0001 : 4'b0000;
      set_data(0, 16'(word));
      @(negedge clk);
      check($sformatf("single_c%0d_wen", c), 32'(fifo_wen), 32'(pat31[c-1]));
      if (pat31[c-1]) check($sformatf("single_c%0d_wdata", c), 32'(fifo_wdata), 32'(word));
      @(posedge clk);
      if (fifo_wen) word++;
      #1;
    end
    check("single_words", 32'(word), 32'd7);

    // vector table
    do_reset;
    for (int i = 0; i < NREQ; i++) set_data(i, 16'hA000 + 16'(i));
    for (int v = 0; v < 16; v++) begin
      req_valid = tbl[v].valid;
      fifo_full = tbl[v].full;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(tbl[v].ready));
      check($sformatf("tbl%0d_wen", v), 32'(fifo_wen), 32'(tbl[v].wen));
      check($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
      if (tbl[v].busy) check($sformatf("tbl%0d_grant", v), 32'(grant_id), 32'(tbl[v].grant));
      if (tbl[v].wen)
        check($sformatf("tbl%0d_wdata", v), 32'(fifo_wdata), 32'h0000A000 + 32'(tbl[v].grant));
      next_cyc;
    end

    // full stall: owner 2, two words, full for five cycles, two more words
    do_reset;
    req_valid = 4'b0100;
    k      = 0;
    s0     = '0;
    wen33  = 11'b01100000110;
    busy33 = 11'b01111111110;
    for (int c = 1; c <= 11; c++) begin
      fifo_full = (c >= 4 && c <= 8);
      set_data(2, 16'h2000 + 16'(k));
      @(negedge clk);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      if (c == 4) s0 = stall_cnt;
`endif
      check($sformatf("stall_c%0d_wen", c), 32'(fifo_wen), 32'(wen33[c-1]));
      check($sformatf("stall_c%0d_busy", c), 32'(busy), 32'(busy33[c-1]));
      if (busy33[c-1]) check($sformatf("stall_c%0d_grant", c), 32'(grant_id), 32'd2);
      if (wen33[c-1]) check($sformatf("stall_c%0d_wdata", c), 32'(fifo_wdata), 32'h2000 + 32'(k));
      @(posedge clk);
      if (fifo_wen) k++;
      #1;
    end
    fifo_full = 1'b0;
    check("stall_words", 32'(k), 32'd4);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("stall_cnt_delta", 32'(stall_cnt - s0), 32'd5);
`endif

    // reset in the middle of an owner-1 burst, with rr moved away from 0 beforehand
    do_reset;
    set_data(0, 16'h0BEE);
    set_data(1, 16'h1111);
    set_data(2, 16'h2222);
    req_valid = 4'b0100;
    next_cyc;                       // IDLE -> owner 2
    @(negedge clk);
    check("mid_pre_grant2", 32'(grant_id), 32'd2);
    next_cyc;
    req_valid = 4'b0010;            // owner 2 drops valid: release, rr = 3
    next_cyc;                       // IDLE -> owner 1
    next_cyc;
    @(negedge clk);
    check("mid_pre_grant1", 32'(grant_id), 32'd1);
    check("mid_pre_wen", 32'(fifo_wen), 32'd1);
    next_cyc;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_wen", 32'(fifo_wen), 32'h0);
    check("mid_rst_grant", 32'(grant_id), 32'h0);
    check("mid_rst_wdata", 32'(fifo_wdata), 32'h0BEE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("mid_post_idle", 32'(busy), 32'h0);
    next_cyc;
    @(negedge clk);
    check("mid_post_busy", 32'(busy), 32'h1);
    check("mid_post_grant", 32'(grant_id), 32'd1);
    next_cyc;

    // randomized run against the reference model
    do_reset;
    m_busy = 1'b0; m_owner = 0; m_rr = 0; m_cnt = 0; m_stall = '0;
    dut_writes = 0; model_writes = 0;
    for (int i = 0; i < NREQ; i++) head[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 65);
        set_data(i, mkword(i, head[i]));
      end
      fifo_full = ($urandom_range(0, 99) < 25);
      @(negedge clk);
      exp_ready = (m_busy && !fifo_full) ? (4'b0001 << m_owner) : 4'b0000;
      exp_wen   = m_busy && req_valid[m_owner] && !fifo_full;
      check("rnd_busy", 32'(busy), 32'(m_busy));
      check("rnd_ready", 32'(req_ready), 32'(exp_ready));
      check("rnd_wen", 32'(fifo_wen), 32'(exp_wen));
      if (m_busy) check("rnd_grant", 32'(grant_id), 32'(m_owner));
      if (exp_wen) check("rnd_wdata", 32'(fifo_wdata), 32'(mkword(m_owner, head[m_owner])));
      if (fifo_wen) dut_writes++;
      if (!m_busy) begin
        for (int j = 0; j < NREQ; j++) begin
          m_j = (m_rr + j) % NREQ;
          if (!m_busy && req_valid[m_j]) begin
            m_busy  = 1'b1;
            m_owner = m_j;
            m_cnt   = 0;
          end
        end
      end else if (!req_valid[m_owner]) begin
        m_busy = 1'b0;
        m_rr   = (m_owner + 1) % NREQ;
      end else if (fifo_full) begin
        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      end else begin
        head[m_owner]++;
        model_writes++;
        m_cnt++;
        if (m_cnt == BURST_MAX) begin
          m_busy = 1'b0;
          m_rr   = (m_owner + 1) % NREQ;
        end
      end
      next_cyc;
    end
    check("rnd_total_words", 32'(dut_writes), 32'(model_writes));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal values 2, 4 or 8.
REQ-002 Parameter WIDTH, default 16, data width; equals the FIFO write data width.
REQ-003 Parameter BURST_MAX, default 4, maximum words per grant; legal range 1..15.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous, active-low reset.
REQ-006 Port req_valid, input, NREQ, requester i has a word on req_data.
REQ-007 Port req_data, input, NREQ*WIDTH, requester i word in bits [i*WIDTH +: WIDTH].
REQ-008 Port req_ready, output, NREQ, word of requester i accepted this cycle when req_valid[i] is also high.
REQ-009 Port fifo_full, input, 1, full flag from the shared FIFO.
REQ-010 Port fifo_wen, output, 1, FIFO write enable.
REQ-011 Port fifo_wdata, output, WIDTH, FIFO write data.
REQ-012 Port grant_id, output, log2(NREQ), current owner index; valid only while busy is high.
REQ-013 Port busy, output, 1, high in state BURST.

Function
REQ-014 FSM states: IDLE and BURST; registers: owner, rr_ptr, and burst count cnt (4 bits).
REQ-015 IDLE: if any req_valid is high, owner <= first valid index searching from rr_ptr upward with modulo-NREQ wrap; cnt <= 0; next state BURST. Otherwise stay in IDLE.
REQ-016 IDLE: req_ready is all-zero and fifo_wen is 0, giving a one-cycle arbitration bubble.
REQ-017 BURST: req_ready[owner] = ~fifo_full; all other req_ready bits are 0.
REQ-018 Combinational outputs: fifo_wen = req_valid[owner] & req_ready[owner]; fifo_wdata = req_data slice of owner. The FIFO is never written while fifo_full is high.
REQ-019 Each BURST transfer increments cnt by 1.
REQ-020 BURST -> IDLE on a transfer that makes cnt equal BURST_MAX, or in any cycle where req_valid[owner] is 0; on that exit rr_ptr <= owner+1 mod NREQ.
REQ-021 In BURST, a cycle with fifo_full high and req_valid[owner] high holds owner, cnt and state unchanged; a full FIFO never forces release.
REQ-022 Requesters other than owner see req_ready low; their valid/data are ignored and never dropped.
REQ-023 Word loss and duplication are forbidden: exactly one FIFO write per valid&ready handshake.
REQ-024 busy = (state == BURST); grant_id = owner.

Reset
REQ-025 While rst_n is low: state = IDLE, owner = 0, rr_ptr = 0, cnt = 0, and, where compiled in, stall_cnt = 0.
REQ-026 During reset, outputs are req_ready = 0, fifo_wen = 0, busy = 0 and grant_id = 0; fifo_wdata equals the requester-0 slice.
REQ-027 Reset asserted mid-burst aborts the burst immediately; a word accepted in the same cycle as reset assertion is treated as not accepted.

Configuration
REQ-028 Macro FIFO_WR_ARB_STALL_CNT_EN defined: adds output port stall_cnt, 16 bits.
REQ-029 stall_cnt increments in every BURST cycle with req_valid[owner] & fifo_full, and saturates at 0xFFFF.
REQ-030 Macro FIFO_WR_ARB_STALL_CNT_EN undefined: no stall_cnt port or logic; all other behaviour is identical.

Verification
REQ-031 Single requester: NREQ=4, BURST_MAX=4, req_valid=0001 held, data 1..6. Required response: writes 1-4 on cycles 2-5, bubble on cycle 6, writes 5-6 on cycles 7-8.
REQ-032 All valid: req_valid=1111 held. Required response: grant_id sequence 0,1,2,3,0, each with 4 words, one idle bubble between grants.
REQ-033 Full stall: owner 2 mid-burst, cnt=2, fifo_full high 5 cycles. Required response: fifo_wen=0, grant_id=2 held, cnt=2; remaining 2 words written after full drops; stall_cnt += 5 when the macro is on.
REQ-034 Early release: owner 1 drops req_valid after 2 words while requester 3 is valid. Required response: IDLE next cycle, rr_ptr=2, then grant_id=3.
REQ-035 Wrap-around: rr_ptr=3, req_valid=1001. Required response: grant 3 first, then grant 0.
REQ-036 Reset mid-burst: rst_n low for 1 cycle during owner 1 burst. Required response: outputs reset asynchronously; first grant after release goes to the lowest valid index from 0.
